// File: rtl/tjpu_stream_router.sv
// Routes the TJPU core's input/output AXI-Stream between the DDR DMAs and an internal loopback FIFO;
// routing changes wait for packet boundaries. Define STREAM_ROUTER_STATS_EN to enable the beat/packet counters.
module tjpu_stream_router #(
  parameter int DATA_W   = 256,
  parameter int LB_DEPTH = 512,
  parameter int CNT_W    = $clog2(LB_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_strobe,
  input  logic                cfg_in_sel,
  input  logic                cfg_out_sel,
  input  logic                core_rd_start,
  input  logic                core_wr_start,
  output logic                dma_rd_start,
  output logic                dma_wr_start,
  input  logic [DATA_W-1:0]   dma_rd_tdata,
  input  logic                dma_rd_tvalid,
  input  logic                dma_rd_tlast,
  output logic                dma_rd_tready,
  output logic [DATA_W-1:0]   core_s_tdata,
  output logic                core_s_tvalid,
  output logic                core_s_tlast,
  input  logic                core_s_tready,
  input  logic [DATA_W-1:0]   core_m_tdata,
  input  logic                core_m_tvalid,
  input  logic                core_m_tlast,
  output logic                core_m_tready,
  output logic [DATA_W-1:0]   dma_wr_tdata,
  output logic                dma_wr_tvalid,
  output logic                dma_wr_tlast,
  output logic [DATA_W/8-1:0] dma_wr_tkeep,
  input  logic                dma_wr_tready,
  output logic                cur_in_sel,
  output logic                cur_out_sel,
  output logic                cfg_pending,
  output logic [CNT_W-1:0]    lb_count,
  output logic                lb_full,
  output logic                lb_empty,
  input  logic                stat_clr,
  output logic [31:0]         stat_in_beats,
  output logic [31:0]         stat_out_beats,
  output logic [31:0]         stat_pkts
);

  localparam int PTR_W  = $clog2(LB_DEPTH);
  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state_reg, state_next;
  logic              cur_in_sel_reg, cur_in_sel_next;
  logic              cur_out_sel_reg, cur_out_sel_next;
  logic              req_in_reg, req_in_next;
  logic              req_out_reg, req_out_next;
  logic              in_pkt_reg, out_pkt_reg;
  logic              dma_rd_start_reg, dma_wr_start_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [DATA_W:0]   mem [LB_DEPTH];
  logic [DATA_W:0]   head_reg;
  logic              lb_wr, lb_rd;
  logic              in_acc, out_acc, in_bound, out_bound;
  logic              tgt_in, tgt_out;

  assign lb_full  = (count_reg == CNT_W'(LB_DEPTH));
  assign lb_empty = (count_reg == '0);
  assign lb_count = count_reg;
  assign lb_wr    = cur_out_sel_reg & core_m_tvalid & ~lb_full;
  assign lb_rd    = cur_in_sel_reg & core_s_tready & ~lb_empty;

  // Stream muxes; valids never depend on the opposite tready.
  always_comb begin
    if (cur_in_sel_reg) begin
      core_s_tvalid = ~lb_empty;
      core_s_tdata  = head_reg[DATA_W-1:0];
      core_s_tlast  = head_reg[DATA_W];
      dma_rd_tready = 1'b0;
    end else begin
      core_s_tvalid = dma_rd_tvalid;
      core_s_tdata  = dma_rd_tdata;
      core_s_tlast  = dma_rd_tlast;
      dma_rd_tready = core_s_tready;
    end
  end

  assign core_m_tready = cur_out_sel_reg ? ~lb_full : dma_wr_tready;
  assign dma_wr_tvalid = ~cur_out_sel_reg & core_m_tvalid;
  assign dma_wr_tdata  = cur_out_sel_reg ? '0 : core_m_tdata;
  assign dma_wr_tlast  = ~cur_out_sel_reg & core_m_tlast;
  assign dma_wr_tkeep  = {KEEP_W{dma_wr_tvalid}};

  assign rd_ptr_next = lb_rd ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (lb_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg <= rd_ptr_next;
      case ({lb_wr, lb_rd})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (lb_wr) mem[wr_ptr_reg] <= {core_m_tlast, core_m_tdata};
  end

  // Registered head prefetch; the forward covers a write landing on the next head slot.
  always_ff @(posedge clk) begin
    if (lb_wr && (wr_ptr_reg == rd_ptr_next)) head_reg <= {core_m_tlast, core_m_tdata};
    else                                      head_reg <= mem[rd_ptr_next];
  end

  assign in_acc    = core_s_tvalid & core_s_tready;
  assign out_acc   = core_m_tvalid & core_m_tready;
  assign in_bound  = in_acc ? core_s_tlast : ~in_pkt_reg;
  assign out_bound = out_acc ? core_m_tlast : ~out_pkt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_pkt_reg  <= 1'b0;
      out_pkt_reg <= 1'b0;
    end else begin
      if (in_acc)  in_pkt_reg  <= ~core_s_tlast;
      if (out_acc) out_pkt_reg <= ~core_m_tlast;
    end
  end

  assign tgt_in  = cfg_strobe ? cfg_in_sel  : req_in_reg;
  assign tgt_out = cfg_strobe ? cfg_out_sel : req_out_reg;

  always_comb begin
    state_next       = state_reg;
    req_in_next      = req_in_reg;
    req_out_next     = req_out_reg;
    cur_in_sel_next  = cur_in_sel_reg;
    cur_out_sel_next = cur_out_sel_reg;
    case (state_reg)
      IDLE: begin
        if (cfg_strobe) begin
          req_in_next  = cfg_in_sel;
          req_out_next = cfg_out_sel;
          state_next   = PEND;
        end
      end
      PEND: begin
        req_in_next  = tgt_in;
        req_out_next = tgt_out;
        if (in_bound)  cur_in_sel_next  = tgt_in;
        if (out_bound) cur_out_sel_next = tgt_out;
        if ((cur_in_sel_next == tgt_in) && (cur_out_sel_next == tgt_out)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      req_in_reg       <= 1'b0;
      req_out_reg      <= 1'b0;
      cur_in_sel_reg   <= 1'b0;
      cur_out_sel_reg  <= 1'b0;
      dma_rd_start_reg <= 1'b0;
      dma_wr_start_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      req_in_reg       <= req_in_next;
      req_out_reg      <= req_out_next;
      cur_in_sel_reg   <= cur_in_sel_next;
      cur_out_sel_reg  <= cur_out_sel_next;
      dma_rd_start_reg <= core_rd_start & ~cur_in_sel_reg;
      dma_wr_start_reg <= core_wr_start & ~cur_out_sel_reg;
    end
  end

  assign cur_in_sel   = cur_in_sel_reg;
  assign cur_out_sel  = cur_out_sel_reg;
  assign cfg_pending  = (state_reg == PEND);
  assign dma_rd_start = dma_rd_start_reg;
  assign dma_wr_start = dma_wr_start_reg;

`ifdef STREAM_ROUTER_STATS_EN
  logic [2:0]  stat_inc;
  logic [95:0] stat_vec;

  // Order: core input beats, core output beats, core output packets.
  assign stat_inc = {out_acc & core_m_tlast, out_acc, in_acc};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [31:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (!rst_n || stat_clr)                           cnt_reg <= '0;
      else if (stat_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) cnt_reg <= cnt_reg + 32'd1;
    end
    assign stat_vec[gi*32 +: 32] = cnt_reg;
  end

  assign stat_in_beats  = stat_vec[31:0];
  assign stat_out_beats = stat_vec[63:32];
  assign stat_pkts      = stat_vec[95:64];
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_in_beats   = '0;
  assign stat_out_beats  = '0;
  assign stat_pkts       = '0;
`endif

endmodule

// File: tb/tb_tjpu_stream_router.sv
// Self-checking bench for tjpu_stream_router: directed scenarios plus randomized traffic
// checked against a queue-based model of routing, loopback FIFO and packet-boundary switching.
module tb_tjpu_stream_router;

  localparam int DW = 32;
  localparam int D  = 16;
  localparam int CW = $clog2(D + 1);
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_strobe, cfg_in_sel, cfg_out_sel;
  logic          core_rd_start, core_wr_start, dma_rd_start, dma_wr_start;
  logic [DW-1:0] dma_rd_tdata;
  logic          dma_rd_tvalid, dma_rd_tlast, dma_rd_tready;
  logic [DW-1:0] core_s_tdata;
  logic          core_s_tvalid, core_s_tlast, core_s_tready;
  logic [DW-1:0] core_m_tdata;
  logic          core_m_tvalid, core_m_tlast, core_m_tready;
  logic [DW-1:0] dma_wr_tdata;
  logic          dma_wr_tvalid, dma_wr_tlast, dma_wr_tready;
  logic [KW-1:0] dma_wr_tkeep;
  logic          cur_in_sel, cur_out_sel, cfg_pending;
  logic [CW-1:0] lb_count;
  logic          lb_full, lb_empty;
  logic          stat_clr;
  logic [31:0]   stat_in_beats, stat_out_beats, stat_pkts;

  tjpu_stream_router #(.DATA_W(DW), .LB_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_strobe(cfg_strobe), .cfg_in_sel(cfg_in_sel), .cfg_out_sel(cfg_out_sel),
    .core_rd_start(core_rd_start), .core_wr_start(core_wr_start),
    .dma_rd_start(dma_rd_start), .dma_wr_start(dma_wr_start),
    .dma_rd_tdata(dma_rd_tdata), .dma_rd_tvalid(dma_rd_tvalid), .dma_rd_tlast(dma_rd_tlast),
    .dma_rd_tready(dma_rd_tready),
    .core_s_tdata(core_s_tdata), .core_s_tvalid(core_s_tvalid), .core_s_tlast(core_s_tlast),
    .core_s_tready(core_s_tready),
    .core_m_tdata(core_m_tdata), .core_m_tvalid(core_m_tvalid), .core_m_tlast(core_m_tlast),
    .core_m_tready(core_m_tready),
    .dma_wr_tdata(dma_wr_tdata), .dma_wr_tvalid(dma_wr_tvalid), .dma_wr_tlast(dma_wr_tlast),
    .dma_wr_tkeep(dma_wr_tkeep), .dma_wr_tready(dma_wr_tready),
    .cur_in_sel(cur_in_sel), .cur_out_sel(cur_out_sel), .cfg_pending(cfg_pending),
    .lb_count(lb_count), .lb_full(lb_full), .lb_empty(lb_empty),
    .stat_clr(stat_clr), .stat_in_beats(stat_in_beats), .stat_out_beats(stat_out_beats),
    .stat_pkts(stat_pkts)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [DW:0] mq[$];
  bit m_in_sel, m_out_sel, m_pend, m_req_in, m_req_out, m_in_mid, m_out_mid;
  bit m_rd_start, m_wr_start;

  function automatic bit m_s_valid();
    return m_in_sel ? (mq.size() != 0) : dma_rd_tvalid;
  endfunction

  function automatic logic [DW:0] m_s_word();
    if (m_in_sel) return (mq.size() != 0) ? mq[0] : '0;
    return {dma_rd_tlast, dma_rd_tdata};
  endfunction

  function automatic bit m_m_ready();
    return m_out_sel ? (mq.size() < D) : dma_wr_tready;
  endfunction

  task automatic model_update();
    bit s_acc, s_last, m_acc, in_ok, out_ok, t_in, t_out;
    logic [DW:0] s_w;
    if (!rst_n) begin
      mq.delete();
      m_in_sel = 0; m_out_sel = 0; m_pend = 0; m_req_in = 0; m_req_out = 0;
      m_in_mid = 0; m_out_mid = 0; m_rd_start = 0; m_wr_start = 0;
      return;
    end
    s_w    = m_s_word();
    s_last = s_w[DW];
    s_acc  = m_s_valid() && core_s_tready;
    m_acc  = core_m_tvalid && m_m_ready();
    in_ok  = s_acc ? s_last : !m_in_mid;
    out_ok = m_acc ? core_m_tlast : !m_out_mid;
    m_rd_start = core_rd_start && !m_in_sel;
    m_wr_start = core_wr_start && !m_out_sel;
    if (s_acc) m_in_mid = !s_last;
    if (m_acc) m_out_mid = !core_m_tlast;
    if (s_acc && m_in_sel) void'(mq.pop_front());
    if (m_acc && m_out_sel) mq.push_back({core_m_tlast, core_m_tdata});
    if (m_pend) begin
      t_in  = cfg_strobe ? cfg_in_sel  : m_req_in;
      t_out = cfg_strobe ? cfg_out_sel : m_req_out;
      if (in_ok)  m_in_sel  = t_in;
      if (out_ok) m_out_sel = t_out;
      m_req_in = t_in; m_req_out = t_out;
      m_pend = (m_in_sel != t_in) || (m_out_sel != t_out);
    end else if (cfg_strobe) begin
      m_req_in = cfg_in_sel; m_req_out = cfg_out_sel; m_pend = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    cfg_strobe = 0; cfg_in_sel = 0; cfg_out_sel = 0;
    core_rd_start = 0; core_wr_start = 0;
    dma_rd_tvalid = 0; dma_rd_tlast = 0; dma_rd_tdata = '0;
    core_m_tvalid = 0; core_m_tlast = 0; core_m_tdata = '0;
    core_s_tready = 0; dma_wr_tready = 0; stat_clr = 0;
  endtask

  task automatic do_cfg(input bit in_s, input bit out_s);
    int k;
    idle_inputs();
    cfg_strobe = 1; cfg_in_sel = in_s; cfg_out_sel = out_s;
    tick();
    cfg_strobe = 0;
    k = 0;
    while (m_pend && k < 50) begin tick(); k++; end
    @(negedge clk);
    n_checks++;
    if (cur_in_sel !== in_s || cur_out_sel !== out_s || cfg_pending !== 1'b0)
      $display("FAIL cfg_apply: got in=%0b out=%0b pend=%0b, want in=%0b out=%0b pend=0",
               cur_in_sel, cur_out_sel, cfg_pending, in_s, out_s);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    @(negedge clk);
    n_checks++; if (cur_in_sel !== 1'b0 || cur_out_sel !== 1'b0) $display("FAIL rst_sel: got %0b%0b want 00", cur_in_sel, cur_out_sel); else n_pass++;
    n_checks++; if (cfg_pending !== 1'b0) $display("FAIL rst_pending: got %0b want 0", cfg_pending); else n_pass++;
    n_checks++; if (lb_count !== '0 || lb_empty !== 1'b1 || lb_full !== 1'b0) $display("FAIL rst_fifo: got cnt=%0d e=%0b f=%0b want 0/1/0", lb_count, lb_empty, lb_full); else n_pass++;
    n_checks++; if (dma_rd_start !== 1'b0 || dma_wr_start !== 1'b0) $display("FAIL rst_start: got %0b%0b want 00", dma_rd_start, dma_wr_start); else n_pass++;
`ifndef STREAM_ROUTER_STATS_EN
    n_checks++; if ((stat_in_beats | stat_out_beats | stat_pkts) !== 32'd0) $display("FAIL rst_stats: got %0h/%0h/%0h want 0", stat_in_beats, stat_out_beats, stat_pkts); else n_pass++;
`endif
    $display("reset done");
    tick();
  endtask

  task automatic test_dma_passthrough();
    logic [DW-1:0] w;
    idle_inputs();
    core_s_tready = 1;
    for (int i = 0; i < 4; i++) begin
      w = DW'($urandom);
      dma_rd_tvalid = 1; dma_rd_tdata = w; dma_rd_tlast = (i == 3);
      @(negedge clk);
      n_checks++; if (core_s_tvalid !== 1'b1 || core_s_tdata !== w || core_s_tlast !== (i == 3))
        $display("FAIL pass_beat%0d: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b", i, core_s_tvalid, core_s_tdata, core_s_tlast, w, (i == 3)); else n_pass++;
      n_checks++; if (dma_rd_tready !== 1'b1 || lb_count !== '0) $display("FAIL pass_ready%0d: got rdy=%0b cnt=%0d want 1/0", i, dma_rd_tready, lb_count); else n_pass++;
      $display("dma->core beat %0d data=%h", i, w);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_loopback();
    logic [DW-1:0] w [6];
    do_cfg(0, 1);
    for (int i = 0; i < 6; i++) begin
      w[i] = DW'($urandom);
      core_m_tvalid = 1; core_m_tdata = w[i]; core_m_tlast = (i == 5);
      @(negedge clk);
      n_checks++; if (core_m_tready !== 1'b1 || dma_wr_tvalid !== 1'b0 || dma_wr_tkeep !== '0 || dma_wr_tdata !== '0)
        $display("FAIL lb_push%0d: got rdy=%0b wv=%0b keep=%h wd=%h want 1/0/0/0", i, core_m_tready, dma_wr_tvalid, dma_wr_tkeep, dma_wr_tdata); else n_pass++;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (lb_count !== CW'(6) || lb_empty !== 1'b0) $display("FAIL lb_count6: got %0d e=%0b want 6/0", lb_count, lb_empty); else n_pass++;
    tick();
    do_cfg(1, 1);
    core_s_tready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if (core_s_tvalid !== 1'b1 || core_s_tdata !== w[i] || core_s_tlast !== (i == 5) || dma_rd_tready !== 1'b0)
        $display("FAIL lb_replay%0d: got v=%0b d=%h l=%0b rr=%0b want 1/%h/%0b/0", i, core_s_tvalid, core_s_tdata, core_s_tlast, dma_rd_tready, w[i], (i == 5)); else n_pass++;
      $display("loopback replay beat %0d data=%h", i, w[i]);
      tick();
    end
    @(negedge clk);
    n_checks++; if (lb_empty !== 1'b1 || core_s_tvalid !== 1'b0) $display("FAIL lb_drained: got e=%0b v=%0b want 1/0", lb_empty, core_s_tvalid); else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_boundary();
    logic [DW-1:0] w;
    do_cfg(0, 0);
    dma_wr_tready = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        core_m_tvalid = 0; cfg_strobe = 1; cfg_in_sel = 0; cfg_out_sel = 1;
        @(negedge clk);
        tick();
        cfg_strobe = 0;
      end
      w = DW'($urandom);
      core_m_tvalid = 1; core_m_tdata = w; core_m_tlast = (i == 7);
      @(negedge clk);
      n_checks++; if (dma_wr_tvalid !== 1'b1 || dma_wr_tdata !== w || dma_wr_tlast !== (i == 7) || dma_wr_tkeep !== {KW{1'b1}})
        $display("FAIL bnd_beat%0d: got v=%0b d=%h l=%0b k=%h want 1/%h/%0b/f", i, dma_wr_tvalid, dma_wr_tdata, dma_wr_tlast, dma_wr_tkeep, w, (i == 7)); else n_pass++;
      n_checks++; if (cur_out_sel !== 1'b0 || cfg_pending !== (i >= 2)) $display("FAIL bnd_hold%0d: got sel=%0b pend=%0b want 0/%0b", i, cur_out_sel, cfg_pending, (i >= 2)); else n_pass++;
      $display("core->dma beat %0d data=%h", i, w);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (cur_out_sel !== 1'b1 || cfg_pending !== 1'b0) $display("FAIL bnd_switch: got sel=%0b pend=%0b want 1/0", cur_out_sel, cfg_pending); else n_pass++;
    tick();
  endtask

  task automatic test_full();
    logic [DW:0] first_w;
    int k;
    do_cfg(1, 1);
    for (int i = 0; i < D; i++) begin
      core_m_tvalid = 1; core_m_tdata = DW'($urandom); core_m_tlast = 1;
      if (i == 0) first_w = {1'b1, core_m_tdata};
      @(negedge clk);
      n_checks++; if (core_m_tready !== 1'b1 || lb_count !== CW'(i)) $display("FAIL fill%0d: got rdy=%0b cnt=%0d want 1/%0d", i, core_m_tready, lb_count, i); else n_pass++;
      if (i < 2) begin
        n_checks++; if (core_s_tvalid !== (i == 1)) $display("FAIL fwft_lat%0d: got v=%0b want %0b", i, core_s_tvalid, (i == 1)); else n_pass++;
      end
      tick();
    end
    @(negedge clk);
    n_checks++; if (lb_full !== 1'b1 || core_m_tready !== 1'b0 || lb_count !== CW'(D)) $display("FAIL full: got f=%0b rdy=%0b cnt=%0d want 1/0/%0d", lb_full, core_m_tready, lb_count, D); else n_pass++;
    tick();
    core_m_tvalid = 0; core_s_tready = 1;
    @(negedge clk);
    n_checks++; if ({core_s_tlast, core_s_tdata} !== first_w) $display("FAIL full_head: got %h want %h", {core_s_tlast, core_s_tdata}, first_w); else n_pass++;
    tick();
    core_s_tready = 0;
    @(negedge clk);
    n_checks++; if (lb_count !== CW'(D - 1) || lb_full !== 1'b0) $display("FAIL one_read: got cnt=%0d f=%0b want %0d/0", lb_count, lb_full, D - 1); else n_pass++;
    tick();
    for (int i = 0; i < 4; i++) begin
      core_s_tready = 1; core_m_tvalid = 1; core_m_tdata = DW'($urandom); core_m_tlast = 1;
      @(negedge clk);
      n_checks++; if (lb_count !== CW'(D - 1) || {core_s_tlast, core_s_tdata} !== m_s_word())
        $display("FAIL rw%0d: got cnt=%0d d=%h want %0d/%h", i, lb_count, {core_s_tlast, core_s_tdata}, D - 1, m_s_word()); else n_pass++;
      tick();
    end
    core_m_tvalid = 0; core_s_tready = 1;
    k = 0;
    while (mq.size() != 0 && k < 2 * D) begin tick(); k++; end
    @(negedge clk);
    n_checks++; if (lb_empty !== 1'b1 || lb_count !== '0) $display("FAIL full_drain: got e=%0b cnt=%0d want 1/0", lb_empty, lb_count); else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_dma_start();
    idle_inputs();
    core_rd_start = 1; core_wr_start = 1;
    tick();
    core_rd_start = 0; core_wr_start = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (dma_rd_start !== 1'b0 || dma_wr_start !== 1'b0) $display("FAIL start_gated%0d: got %0b%0b want 00", i, dma_rd_start, dma_wr_start); else n_pass++;
      tick();
    end
    do_cfg(0, 0);
    core_rd_start = 1; core_wr_start = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (dma_rd_start !== (i == 1) || dma_wr_start !== (i == 1)) $display("FAIL start_pulse%0d: got %0b%0b want %0b", i, dma_rd_start, dma_wr_start, (i == 1)); else n_pass++;
      tick();
      core_rd_start = 0; core_wr_start = 0;
    end
    $display("dma start pulse checked");
  endtask

  task automatic test_random();
    bit exp_sv, exp_wv;
    logic [DW:0] exp_sw;
    for (int c = 0; c < 800; c++) begin
      dma_rd_tvalid = ($urandom_range(3, 0) != 0); dma_rd_tdata = DW'($urandom); dma_rd_tlast = ($urandom_range(3, 0) == 0);
      core_m_tvalid = ($urandom_range(3, 0) != 0); core_m_tdata = DW'($urandom); core_m_tlast = ($urandom_range(3, 0) == 0);
      core_s_tready = ($urandom_range(2, 0) != 0); dma_wr_tready = ($urandom_range(2, 0) != 0);
      cfg_strobe = ($urandom_range(24, 0) == 0); cfg_in_sel = $urandom_range(1, 0) == 1; cfg_out_sel = $urandom_range(1, 0) == 1;
      core_rd_start = ($urandom_range(7, 0) == 0); core_wr_start = ($urandom_range(7, 0) == 0);
      @(negedge clk);
      exp_sv = m_s_valid(); exp_sw = m_s_word();
      exp_wv = !m_out_sel && core_m_tvalid;
      n_checks++; if (core_s_tvalid !== exp_sv) $display("FAIL rnd_sv c%0d: got %0b want %0b", c, core_s_tvalid, exp_sv); else n_pass++;
      if (exp_sv) begin
        n_checks++; if ({core_s_tlast, core_s_tdata} !== exp_sw) $display("FAIL rnd_sd c%0d: got %h want %h", c, {core_s_tlast, core_s_tdata}, exp_sw); else n_pass++;
      end
      n_checks++; if (dma_rd_tready !== (!m_in_sel && core_s_tready)) $display("FAIL rnd_rr c%0d: got %0b want %0b", c, dma_rd_tready, !m_in_sel && core_s_tready); else n_pass++;
      n_checks++; if (core_m_tready !== m_m_ready()) $display("FAIL rnd_mr c%0d: got %0b want %0b", c, core_m_tready, m_m_ready()); else n_pass++;
      n_checks++; if (dma_wr_tvalid !== exp_wv || dma_wr_tkeep !== (exp_wv ? {KW{1'b1}} : {KW{1'b0}})) $display("FAIL rnd_wv c%0d: got v=%0b k=%h want %0b", c, dma_wr_tvalid, dma_wr_tkeep, exp_wv); else n_pass++;
      n_checks++; if (dma_wr_tdata !== (m_out_sel ? '0 : core_m_tdata)) $display("FAIL rnd_wd c%0d: got %h", c, dma_wr_tdata); else n_pass++;
      if (exp_wv) begin
        n_checks++; if (dma_wr_tlast !== core_m_tlast) $display("FAIL rnd_wl c%0d: got %0b want %0b", c, dma_wr_tlast, core_m_tlast); else n_pass++;
      end
      n_checks++; if (cur_in_sel !== m_in_sel || cur_out_sel !== m_out_sel || cfg_pending !== m_pend)
        $display("FAIL rnd_cfg c%0d: got %0b%0b p=%0b want %0b%0b p=%0b", c, cur_in_sel, cur_out_sel, cfg_pending, m_in_sel, m_out_sel, m_pend); else n_pass++;
      n_checks++; if (lb_count !== CW'(mq.size()) || lb_full !== (mq.size() == D) || lb_empty !== (mq.size() == 0))
        $display("FAIL rnd_cnt c%0d: got %0d f=%0b e=%0b want %0d", c, lb_count, lb_full, lb_empty, mq.size()); else n_pass++;
      n_checks++; if (dma_rd_start !== m_rd_start || dma_wr_start !== m_wr_start) $display("FAIL rnd_start c%0d: got %0b%0b want %0b%0b", c, dma_rd_start, dma_wr_start, m_rd_start, m_wr_start); else n_pass++;
      tick();
    end
    $display("random traffic: 800 cycles");
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    do_cfg(0, 1);
    for (int i = 0; i < 5; i++) begin
      core_m_tvalid = 1; core_m_tdata = DW'($urandom); core_m_tlast = 0;
      tick();
    end
    core_m_tvalid = 0; cfg_strobe = 1; cfg_in_sel = 0; cfg_out_sel = 0;
    tick();
    cfg_strobe = 0;
    @(negedge clk);
    n_checks++; if (lb_count !== CW'(5) || cfg_pending !== 1'b1) $display("FAIL mid_pre: got cnt=%0d pend=%0b want 5/1", lb_count, cfg_pending); else n_pass++;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    n_checks++; if (lb_count !== '0 || lb_empty !== 1'b1) $display("FAIL mid_fifo: got cnt=%0d e=%0b want 0/1", lb_count, lb_empty); else n_pass++;
    n_checks++; if (cur_in_sel !== 1'b0 || cur_out_sel !== 1'b0 || cfg_pending !== 1'b0)
      $display("FAIL mid_cfg: got %0b%0b p=%0b want 00 p=0", cur_in_sel, cur_out_sel, cfg_pending); else n_pass++;
    $display("reset mid-packet done");
    tick();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_dma_passthrough();
    test_loopback();
    test_boundary();
    test_full();
    test_dma_start();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tjpu_stream_router.md
Name: tjpu_stream_router

Overview:
Parametrised successor to the fixed TJPU stream mux, with an Out_Buffer/In_Buffer loopback pair folded in. Routes the TJPU core's AXI-Stream input from either the DDR read DMA or an internal loopback FIFO, and its output to either the DDR write DMA or the same FIFO. A mode change is applied only on packet boundaries, so a switch never splits a packet. It sits between the TJPU core and system_wrapper.

Parameters:
DATA_W, 256, stream data width in bits (multiple of 8)
LB_DEPTH, 512, loopback FIFO depth in beats (power of 2, >= 4)
CNT_W, $clog2(LB_DEPTH+1), width of the FIFO occupancy count

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous active-low reset
cfg_strobe  in  1  one-cycle request to change routing
cfg_in_sel  in  1  requested input source: 0 = DMA read, 1 = loopback
cfg_out_sel  in  1  requested output sink: 0 = DMA write, 1 = loopback
core_rd_start  in  1  core request to start a DMA read
core_wr_start  in  1  core request to start a DMA write
dma_rd_start  out  1  gated read-DMA start pulse
dma_wr_start  out  1  gated write-DMA start pulse
dma_rd_tdata/tvalid/tlast  in  DATA_W/1/1  read-DMA stream
dma_rd_tready  out  1  ready to the read DMA
core_s_tdata/tvalid/tlast  out  DATA_W/1/1  stream into the core
core_s_tready  in  1  ready from the core
core_m_tdata/tvalid/tlast  in  DATA_W/1/1  stream out of the core
core_m_tready  out  1  ready to the core
dma_wr_tdata/tvalid/tlast  out  DATA_W/1/1  write-DMA stream
dma_wr_tkeep  out  DATA_W/8  all ones while dma_wr_tvalid is high, otherwise 0
dma_wr_tready  in  1  ready from the write DMA
cur_in_sel, cur_out_sel  out  1 each  routing currently in effect
cfg_pending  out  1  a requested change is waiting for a packet boundary
lb_count  out  CNT_W  loopback FIFO occupancy
lb_full, lb_empty  out  1 each  loopback FIFO flags

Behaviour:
- Reset (rst_n low at the clk edge): cur_in_sel = 0 and cur_out_sel = 0; cfg_pending = 0; FIFO emptied (lb_count = 0, lb_empty = 1, lb_full = 0); the dma_*_start outputs are 0; both packet-in-progress flags are cleared. Reset mid-packet discards FIFO contents and any pending change.
- Loopback FIFO: width DATA_W+1 (data plus tlast), first-word-fall-through.
  - Write when cur_out_sel = 1, core_m_tvalid = 1 and lb_full = 0.
  - Read when cur_in_sel = 1, core_s_tready = 1 and lb_empty = 0.
  - No write-to-read bypass: a word written into an empty FIFO is visible on core_s_* one cycle later.
  - Simultaneous read and write leaves lb_count unchanged. Pointers wrap modulo LB_DEPTH.
- Input path:
  - cur_in_sel = 0: core_s_* = dma_rd_*; dma_rd_tready = core_s_tready.
  - cur_in_sel = 1: core_s_* = FIFO head, with core_s_tvalid = !lb_empty; dma_rd_tready = 0.
- Output path:
  - cur_out_sel = 0: dma_wr_* = core_m_*; core_m_tready = dma_wr_tready.
  - cur_out_sel = 1: core_m_tready = !lb_full; dma_wr_tvalid = 0 and dma_wr_tdata = 0.
- Packet tracking, separate for each side: flag in_pkt is set on an accepted beat with tlast = 0 and cleared on an accepted beat with tlast = 1.
- Reconfiguration FSM (IDLE, PEND):
  - cfg_strobe latches the requested selects and enters PEND.
  - A strobe while in PEND overwrites the latched request (the latest request wins).
  - For each side independently, the new select takes effect at the clk edge where that side's in_pkt is 0 and no non-last beat is accepted, or at the edge that accepts a tlast beat.
  - The FSM returns to IDLE when both sides have applied the change. cfg_pending is high in PEND.
  - If the requested select equals the current one, that side applies the change immediately.
- DMA start gating: dma_rd_start <= core_rd_start & !cur_in_sel, and dma_wr_start <= core_wr_start & !cur_out_sel. Both are registered with a latency of 1 cycle.
- Throughput: 1 beat per cycle on every path; no combinational path from tready to tvalid.

Optional Feature:
STREAM_ROUTER_STATS_EN: adds outputs stat_in_beats, stat_out_beats and stat_pkts (32 bits each, saturating at 0xFFFFFFFF) and input stat_clr.
- stat_clr clears the counters the next cycle and takes priority over counting.
- Without the macro, the ports still exist, the counters read 0 and stat_clr is ignored.

Test Plan:
- Reset, then 4 DMA beats with tlast on beat 4 while core_s_tready = 1 -> core_s_* matches beat for beat; dma_rd_tready = 1; lb_count = 0.
- cfg_out_sel = 1; core emits 6 beats (last = 1); then cfg_in_sel = 1 -> lb_count = 6; core_s replays the 6 beats in order with tlast on beat 6; lb_empty = 1 afterwards.
- cfg_strobe (out_sel = 1) after beat 2 of an 8-beat output packet -> beats 3-8 still go to DMA write; cur_out_sel flips on the beat-8 edge; cfg_pending low the next cycle.
- Fill the FIFO to LB_DEPTH with core_s_tready = 0 -> lb_full = 1 and core_m_tready = 0; one read frees exactly 1 slot; simultaneous read and write keeps lb_count = LB_DEPTH-1.
- core_rd_start pulse with cur_in_sel = 1 -> dma_rd_start stays 0; with cur_in_sel = 0 -> 1-cycle pulse, 1 cycle later.
- rst_n low mid-packet with lb_count = 5 and cfg_pending = 1 -> lb_count = 0, selects = 0, cfg_pending = 0 the next cycle.
